instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- IF stage plus IF/ID pipeline register, directly upstream of the decode/control unit.
- Holds the PC, drives the instruction-memory address, and registers the fetched word with its PC.
- Produces the decode-side fields opCode/funct3/funct7 and the nop bubble flag.
- Handles stall, EX-stage redirect (branch/jump) with a configurable bubble count, and a sticky halt.

Parameters:
- PC_WIDTH, 32, width of PC, addresses and targets.
- RESET_PC, 32'h0, PC value loaded on reset.
- FLUSH_CYCLES, 1, bubbles inserted into IF/ID after a redirect (1..3).
- NOP_INSTR, 32'h00000013, word placed in if_instr whenever a bubble is registered; never opcode 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hazard stall: freeze PC and IF/ID.
- pc_redirect_valid  in  1  taken branch/jump resolved in EX.
- pc_redirect_target  in  PC_WIDTH  redirect address.
- halt  in  1  halt decoded in ID (control-unit halt output).
- imem_addr  out  PC_WIDTH  instruction-memory address; combinational = pc_q.
- imem_data  in  32  instruction word; combinational read of imem_addr.
- if_instr  out  32  registered instruction.
- if_pc  out  PC_WIDTH  PC of if_instr.
- if_pc_plus4  out  PC_WIDTH  if_pc + 4, truncated to PC_WIDTH.
- if_opcode  out  7  if_instr[6:0].
- if_funct3  out  3  if_instr[14:12].
- if_funct7  out  7  if_instr[31:25].
- if_nop  out  1  bubble flag to decode; = nop_q | pc_redirect_valid.
- halted  out  1  core frozen (state HALTED).
- fetch_count  out  32  count of non-bubble words loaded into IF/ID; wraps mod 2^32.

Behaviour:
- Reset (rst_n=0, async):
  - pc_q=RESET_PC; if_instr=NOP_INSTR; if_pc=0; nop_q=1.
  - bubble_cnt=0; state=RUN; fetch_count=0; halted=0.
  - Slice outputs follow if_instr.
- States: RUN, FLUSH, HALTED.
- Per-edge priority: reset > redirect > halt > stall > normal fetch.
- RUN, normal fetch (no stall/redirect/valid halt):
  - pc_q += 4.
  - IF/ID <= {imem_data, pc_q}; nop_q=0; fetch_count += 1.
  - Latency: word at PC appears on if_instr exactly 1 cycle after imem_addr=PC.
- Stall (RUN, stall=1, no redirect):
  - pc_q, IF/ID, nop_q and fetch_count all hold.
  - A multi-cycle stall is indistinguishable from one long cycle.
- Redirect (pc_redirect_valid=1, any state except HALTED; overrides stall and halt):
  - Same cycle: if_nop=1 combinationally, squashing the instruction currently in ID.
  - Edge: pc_q=target; IF/ID <= bubble (NOP_INSTR, nop_q=1).
  - If FLUSH_CYCLES>1: state=FLUSH, bubble_cnt=FLUSH_CYCLES-1; else state stays RUN.
  - No fetch_count increment.
- FLUSH:
  - Each edge loads a bubble and bubble_cnt -= 1; pc_q holds at target.
  - stall does not extend FLUSH; a new redirect reloads pc_q and restarts the count.
  - bubble_cnt reaching 0 -> RUN.
- Halt (halt=1 and if_nop=0, no redirect):
  - Edge: state=HALTED; pc_q holds; IF/ID <= bubble; halted=1.
  - halt is ignored while if_nop=1.
- HALTED:
  - Sticky until rst_n=0; ignores stall, halt and redirect.
  - if_nop = 1 regardless of pc_redirect_valid; no fetch_count change.
- Target handling: not alignment-checked; the low 2 bits pass through.
- PC wrap: 0xFFFFFFFC + 4 -> 0x00000000, with no flag.
- Reset mid-flush or mid-stall: immediately restores the reset values above; no residual bubble_cnt.

Test Plan:
- Reset then 4 free-running cycles, imem returns 0x00A00093 at PC 0, 0x00000033+4k elsewhere -> if_nop=1 during first cycle; if_pc sequence 0,4,8,12; if_instr(0)=0x00A00093; if_opcode=0x13; fetch_count=4.
- stall=1 for 3 cycles at pc_q=8 -> imem_addr stays 8; if_pc stays 4; fetch_count frozen; resumes with if_pc=8 one cycle after release.
- Redirect to 0x40 with stall=1 same cycle, FLUSH_CYCLES=2 -> if_nop=1 that cycle and the next 2; imem_addr=0x40; first valid if_pc=0x40 three cycles later.
- halt=1 with if_nop=0 at if_pc=0x10 -> halted=1 next edge; PC frozen; later redirect to 0x80 ignored; rst_n low restores pc_q=0.
- halt=1 while if_nop=1 (bubble), and halt with simultaneous redirect -> no halt entered; redirect taken.
- Redirect target 0xFFFFFFFC, run 2 cycles -> if_pc sequence 0xFFFFFFFC, 0x00000000; if_pc_plus4=0x00000000 then 0x00000004.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage with PC, IF/ID register, redirect flush and sticky halt
module instruction_fetch_unit #(
    parameter int          PC_WIDTH     = 32,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                pc_redirect_valid,
    input  logic [PC_WIDTH-1:0] pc_redirect_target,
    input  logic                halt,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [PC_WIDTH-1:0] if_pc_plus4,
    output logic [6:0]          if_opcode,
    output logic [2:0]          if_funct3,
    output logic [6:0]          if_funct7,
    output logic                if_nop,
    output logic                halted,
    output logic [31:0]         fetch_count
);

    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t              state, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] ifpc_q, ifpc_d;
    logic                nop_q, nop_d;
    logic [1:0]          bubble_cnt, bubble_cnt_d;
    logic [31:0]         fetch_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc_q        <= RESET_PC[PC_WIDTH-1:0];
            instr_q     <= NOP_INSTR;
            ifpc_q      <= '0;
            nop_q       <= 1'b1;
            bubble_cnt  <= 2'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            ifpc_q      <= ifpc_d;
            nop_q       <= nop_d;
            bubble_cnt  <= bubble_cnt_d;
            fetch_count <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state;
        pc_d          = pc_q;
        instr_d       = instr_q;
        ifpc_d        = ifpc_q;
        nop_d         = nop_q;
        bubble_cnt_d  = bubble_cnt;
        fetch_count_d = fetch_count;
        if (state == HALTED) begin
            state_d = HALTED;
        end else if (pc_redirect_valid) begin
            pc_d         = pc_redirect_target;
            instr_d      = NOP_INSTR;
            nop_d        = 1'b1;
            bubble_cnt_d = FLUSH_RELOAD;
            state_d      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state == FLUSH) begin
            // Bubbles keep coming regardless of stall; pc stays parked on the target.
            instr_d      = NOP_INSTR;
            nop_d        = 1'b1;
            bubble_cnt_d = bubble_cnt - 2'd1;
            if (bubble_cnt <= 2'd1) begin
                state_d = RUN;
            end
        end else if (halt && !nop_q) begin
            state_d = HALTED;
            instr_d = NOP_INSTR;
            nop_d   = 1'b1;
        end else if (!stall) begin
            pc_d          = pc_q + PC_WIDTH'(4);
            instr_d       = imem_data;
            ifpc_d        = pc_q;
            nop_d         = 1'b0;
            fetch_count_d = fetch_count + 32'd1;
        end
    end

    assign imem_addr   = pc_q;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign if_pc_plus4 = ifpc_q + PC_WIDTH'(4);
    assign if_opcode   = instr_q[6:0];
    assign if_funct3   = instr_q[14:12];
    assign if_funct7   = instr_q[31:25];
    assign if_nop      = nop_q | pc_redirect_valid | (state == HALTED);
    assign halted      = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect_target;
    logic        halt;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [6:0]  if_opcode;
    logic [2:0]  if_funct3;
    logic [6:0]  if_funct7;
    logic        if_nop;
    logic        halted;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    instruction_fetch_unit #(
        .PC_WIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2), .NOP_INSTR(32'h00000013)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
        .halt(halt), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_opcode(if_opcode), .if_funct3(if_funct3), .if_funct7(if_funct7),
        .if_nop(if_nop), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr == 32'h0) ? 32'h00A00093 : 32'h00000033 + imem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; pc_redirect_valid = 1'b0;
        pc_redirect_target = 32'h0; halt = 1'b0;
        #12;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", if_instr, 32'h00000013);
        check("rst_pc", if_pc, 32'h0);
        check("rst_nop", {31'd0, if_nop}, 32'd1);
        check("rst_cnt", fetch_count, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_opcode", {25'd0, if_opcode}, 32'h13);
        rst_n = 1'b1;

        step();
        check("f0_pc", if_pc, 32'h0);
        check("f0_instr", if_instr, 32'h00A00093);
        check("f0_opcode", {25'd0, if_opcode}, 32'h13);
        check("f0_funct3", {29'd0, if_funct3}, 32'h0);
        check("f0_funct7", {25'd0, if_funct7}, 32'h0);
        check("f0_nop", {31'd0, if_nop}, 32'd0);
        check("f0_plus4", if_pc_plus4, 32'h4);
        step();
        check("f1_pc", if_pc, 32'h4);
        check("f1_instr", if_instr, 32'h00000037);
        step();
        check("f2_pc", if_pc, 32'h8);
        step();
        check("f3_pc", if_pc, 32'hC);
        check("f3_instr", if_instr, 32'h0000003F);
        check("f3_cnt", fetch_count, 32'd4);
        check("f3_addr", imem_addr, 32'h10);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h10);
            check("stall_pc", if_pc, 32'hC);
            check("stall_cnt", fetch_count, 32'd4);
        end
        stall = 1'b0;
        step();
        check("resume_pc", if_pc, 32'h10);
        check("resume_instr", if_instr, 32'h00000043);
        check("resume_cnt", fetch_count, 32'd5);

        stall = 1'b1; pc_redirect_valid = 1'b1; pc_redirect_target = 32'h40;
        #1;
        check("redir_comb_nop", {31'd0, if_nop}, 32'd1);
        step();
        pc_redirect_valid = 1'b0;
        #1;
        check("flush1_nop", {31'd0, if_nop}, 32'd1);
        check("flush1_addr", imem_addr, 32'h40);
        check("flush1_instr", if_instr, 32'h00000013);
        step();
        check("flush2_nop", {31'd0, if_nop}, 32'd1);
        check("flush2_cnt", fetch_count, 32'd5);
        stall = 1'b0;
        step();
        check("post_flush_pc", if_pc, 32'h40);
        check("post_flush_nop", {31'd0, if_nop}, 32'd0);
        check("post_flush_instr", if_instr, 32'h00000073);
        check("post_flush_cnt", fetch_count, 32'd6);

        halt = 1'b1; pc_redirect_valid = 1'b1; pc_redirect_target = 32'h100;
        step();
        pc_redirect_valid = 1'b0;
        check("halt_redir_halted", {31'd0, halted}, 32'd0);
        check("halt_redir_addr", imem_addr, 32'h100);
        step();
        check("halt_bubble_halted", {31'd0, halted}, 32'd0);
        halt = 1'b0;
        step();
        check("h_fetch_pc", if_pc, 32'h100);
        check("h_fetch_cnt", fetch_count, 32'd7);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halted_set", {31'd0, halted}, 32'd1);
        check("halted_addr", imem_addr, 32'h104);
        check("halted_nop", {31'd0, if_nop}, 32'd1);
        pc_redirect_valid = 1'b1; pc_redirect_target = 32'h80;
        step();
        step();
        pc_redirect_valid = 1'b0;
        check("halted_ignore_redir", imem_addr, 32'h104);
        check("halted_sticky", {31'd0, halted}, 32'd1);
        check("halted_cnt", fetch_count, 32'd7);
        rst_n = 1'b0;
        #1;
        check("async_rst_addr", imem_addr, 32'h0);
        check("async_rst_halted", {31'd0, halted}, 32'd0);
        check("async_rst_cnt", fetch_count, 32'd0);

        step();
        rst_n = 1'b1; pc_redirect_valid = 1'b1; pc_redirect_target = 32'hFFFFFFFC;
        step();
        pc_redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFFFFFC);
        step();
        step();
        check("wrap_pc0", if_pc, 32'hFFFFFFFC);
        check("wrap_plus4_0", if_pc_plus4, 32'h0);
        check("wrap_addr_next", imem_addr, 32'h0);
        step();
        check("wrap_pc1", if_pc, 32'h0);
        check("wrap_plus4_1", if_pc_plus4, 32'h4);
        check("wrap_cnt", fetch_count, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
